// File: rtl/pcp_host_ctrl.sv
// rtl/pcp_host_ctrl.sv - host-side sequencer for the PCP core memories and runs
//
// Converts a 32-bit command/beat stream into PCP IMEM/DMEM write cycles, DMEM
// read-back beats and PCP run control. This block is the only external master
// of the PCP memories and the only initiator of PCP runs.
//
// Ports:
//   i_clock, i_nreset                 clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready           command handshake (ready only in IDLE)
//   i_cmd_op                          0 LOAD_IMEM, 1 LOAD_DMEM, 2 RUN, 3 READ_DMEM
//   i_cmd_addr, i_cmd_count           start word address, word count minus 1
//   i_cmd_offset                      IMEM offset used during RUN
//   i_wr_data/i_wr_valid/o_wr_ready   load beat stream, first beat in the LSBs
//   o_rd_data/o_rd_valid/i_rd_ready   DMEM read-back beat stream
//   o_busy                            high whenever the sequencer is not idle
//   o_run_cycles                      cycles spent in the last RUN (saturating)
//   o_pcp_active, o_pcp_imem_offset   PCP run controls
//   i_pcp_nbusy, i_pcp_done           PCP status (nbusy is not used)
//   o_imem_addr/o_imem_in/o_imem_we   IMEM write port (75-bit words)
//   o_dmem_addr/o_dmem_in/o_dmem_we   DMEM port (256-bit words)
//   i_dmem_out                        DMEM read data, one cycle after address

module pcp_host_ctrl (
    input  logic         i_clock,
    input  logic         i_nreset,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [1:0]   i_cmd_op,
    input  logic [9:0]   i_cmd_addr,
    input  logic [9:0]   i_cmd_count,
    input  logic [3:0]   i_cmd_offset,
    input  logic [31:0]  i_wr_data,
    input  logic         i_wr_valid,
    output logic         o_wr_ready,
    output logic [31:0]  o_rd_data,
    output logic         o_rd_valid,
    input  logic         i_rd_ready,
    output logic         o_busy,
    output logic [31:0]  o_run_cycles,
    output logic         o_pcp_active,
    output logic [3:0]   o_pcp_imem_offset,
    input  logic         i_pcp_nbusy,
    input  logic         i_pcp_done,
    output logic [9:0]   o_imem_addr,
    output logic [74:0]  o_imem_in,
    output logic         o_imem_we,
    output logic [9:0]   o_dmem_addr,
    output logic [255:0] o_dmem_in,
    output logic         o_dmem_we,
    input  logic [255:0] i_dmem_out
);

    localparam logic [1:0] OP_LOAD_IMEM = 2'd0;
    localparam logic [1:0] OP_RUN       = 2'd2;
    localparam logic [1:0] OP_READ_DMEM = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_CAP  = 3'd4,
        S_RD_SEND = 3'd5,
        S_RUN     = 3'd6
    } state_t;

    state_t         r_state;
    logic [1:0]     r_op;
    logic [9:0]     r_addr;
    logic [9:0]     r_count;
    logic [2:0]     r_beat;
    // Word assembler: beats enter at the top and move down, so after the
    // final beat of a word the oldest beat sits in the lowest filled slot.
    // The last beat is taken straight from i_wr_data, hence only 7 slots.
    logic [223:0]   r_asm;
    // Upper 224 bits of the captured DMEM word; bits [31:0] live in o_rd_data.
    logic [223:0]   r_rd_shift;
    logic [31:0]    r_run_cycles;

    logic           w_last_beat;
    logic           w_unused;

    assign w_last_beat  = (r_op == OP_LOAD_IMEM) ? (r_beat == 3'd2) : (r_beat == 3'd7);
    assign o_run_cycles = r_run_cycles;
    assign w_unused     = i_pcp_nbusy;

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state           <= S_IDLE;
            r_op              <= 2'd0;
            r_addr            <= 10'd0;
            r_count           <= 10'd0;
            r_beat            <= 3'd0;
            r_asm             <= '0;
            r_rd_shift        <= '0;
            r_run_cycles      <= 32'd0;
            o_cmd_ready       <= 1'b1;
            o_wr_ready        <= 1'b0;
            o_rd_data         <= 32'd0;
            o_rd_valid        <= 1'b0;
            o_busy            <= 1'b0;
            o_pcp_active      <= 1'b0;
            o_pcp_imem_offset <= 4'd0;
            o_imem_addr       <= 10'd0;
            o_imem_in         <= '0;
            o_imem_we         <= 1'b0;
            o_dmem_addr       <= 10'd0;
            o_dmem_in         <= '0;
            o_dmem_we         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid && o_cmd_ready) begin
                        r_op        <= i_cmd_op;
                        r_addr      <= i_cmd_addr;
                        r_count     <= i_cmd_count;
                        r_beat      <= 3'd0;
                        o_cmd_ready <= 1'b0;
                        o_busy      <= 1'b1;
                        case (i_cmd_op)
                            OP_RUN: begin
                                r_state           <= S_RUN;
                                r_run_cycles      <= 32'd0;
                                o_pcp_active      <= 1'b1;
                                o_pcp_imem_offset <= i_cmd_offset;
                            end
                            OP_READ_DMEM: begin
                                r_state     <= S_RD_ADDR;
                                o_dmem_addr <= i_cmd_addr;
                            end
                            default: begin
                                r_state    <= S_LOAD;
                                o_wr_ready <= 1'b1;
                            end
                        endcase
                    end
                end

                S_LOAD: begin
                    if (i_wr_valid) begin
                        r_asm <= {i_wr_data, r_asm[223:32]};
                        if (w_last_beat) begin
                            r_state    <= S_WRITE;
                            o_wr_ready <= 1'b0;
                            r_beat     <= 3'd0;
                            if (r_op == OP_LOAD_IMEM) begin
                                // Beats 0 and 1 sit in the top two slots; bits 95:75 drop.
                                o_imem_addr <= r_addr;
                                o_imem_in   <= {i_wr_data[10:0], r_asm[223:160]};
                                o_imem_we   <= 1'b1;
                            end else begin
                                o_dmem_addr <= r_addr;
                                o_dmem_in   <= {i_wr_data, r_asm};
                                o_dmem_we   <= 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end

                S_WRITE: begin
                    o_imem_we <= 1'b0;
                    o_dmem_we <= 1'b0;
                    r_addr    <= r_addr + 10'd1;
                    if (r_count == 10'd0) begin
                        r_state     <= S_IDLE;
                        o_cmd_ready <= 1'b1;
                        o_busy      <= 1'b0;
                    end else begin
                        r_count    <= r_count - 10'd1;
                        r_state    <= S_LOAD;
                        o_wr_ready <= 1'b1;
                    end
                end

                // Address was presented on entry; memory returns data next cycle.
                S_RD_ADDR: begin
                    r_state <= S_RD_CAP;
                end

                S_RD_CAP: begin
                    o_rd_data  <= i_dmem_out[31:0];
                    r_rd_shift <= i_dmem_out[255:32];
                    o_rd_valid <= 1'b1;
                    r_beat     <= 3'd0;
                    r_state    <= S_RD_SEND;
                end

                S_RD_SEND: begin
                    if (i_rd_ready) begin
                        if (r_beat == 3'd7) begin
                            o_rd_valid <= 1'b0;
                            r_addr     <= r_addr + 10'd1;
                            if (r_count == 10'd0) begin
                                r_state     <= S_IDLE;
                                o_cmd_ready <= 1'b1;
                                o_busy      <= 1'b0;
                            end else begin
                                r_count     <= r_count - 10'd1;
                                o_dmem_addr <= r_addr + 10'd1;
                                r_state     <= S_RD_ADDR;
                            end
                        end else begin
                            o_rd_data  <= r_rd_shift[31:0];
                            r_rd_shift <= {32'd0, r_rd_shift[223:32]};
                            r_beat     <= r_beat + 3'd1;
                        end
                    end
                end

                S_RUN: begin
                    if (r_run_cycles != 32'hFFFF_FFFF) begin
                        r_run_cycles <= r_run_cycles + 32'd1;
                    end
                    // A zero count marks the first RUN cycle, where a done left
                    // over from a previous run must not end this one.
                    if (i_pcp_done && (r_run_cycles != 32'd0)) begin
                        r_state           <= S_IDLE;
                        o_pcp_active      <= 1'b0;
                        o_pcp_imem_offset <= 4'd0;
                        o_cmd_ready       <= 1'b1;
                        o_busy            <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    o_cmd_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
